// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with registered-read or first-word-fall-through
// output, occupancy-based status flags and sticky overflow/underflow errors.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk_i,
  input  logic                  areset_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);

  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_LVL outside 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_LVL outside 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;

  assign count_o        = count;
  assign fifo_full_o    = (count == DEPTH_C);
  assign fifo_empty_o   = (count == '0);
  assign almost_full_o  = (count >= AFULL_C);
  assign almost_empty_o = (count <= AEMPTY_C);

  // No pass-through: acceptance depends only on the registered flags.
  assign wr_acc = wr_en_i & ~fifo_full_o & ~areset_i;
  assign rd_acc = rd_en_i & ~fifo_empty_o & ~areset_i;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
  end

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= (wr_en_i & fifo_full_o) |
                     (overflow_o & ~err_clr_i);
      underflow_o <= (rd_en_i & fifo_empty_o) |
                     (underflow_o & ~err_clr_i);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head is shown only while occupied, so unwritten storage never leaks.
    assign rd_data_o  = fifo_empty_o ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_valid_o = ~fifo_empty_o;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: a registered-read and an FWFT instance share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] wr_data;
  logic          wr_en, rd_en, err_clr;

  logic [DW-1:0] r_data, f_data;
  logic          r_valid, f_valid;
  logic          r_full, f_full, r_empty, f_empty;
  logic          r_af, f_af, r_ae, f_ae;
  logic [AW:0]   r_count, f_count;
  logic          r_ovf, f_ovf, r_udf, f_udf;
  logic [8:0]    r_stat, f_stat;

  assign r_stat = {r_count, r_full, r_empty, r_af, r_ae};
  assign f_stat = {f_count, f_full, f_empty, f_af, f_ae};

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_reg (
    .clk_i(clk), .areset_i(areset), .wr_data_i(wr_data),
    .wr_en_i(wr_en), .rd_en_i(rd_en), .err_clr_i(err_clr),
    .rd_data_o(r_data), .rd_valid_o(r_valid),
    .fifo_full_o(r_full), .fifo_empty_o(r_empty),
    .almost_full_o(r_af), .almost_empty_o(r_ae),
    .count_o(r_count), .overflow_o(r_ovf), .underflow_o(r_udf)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
    .clk_i(clk), .areset_i(areset), .wr_data_i(wr_data),
    .wr_en_i(wr_en), .rd_en_i(rd_en), .err_clr_i(err_clr),
    .rd_data_o(f_data), .rd_valid_o(f_valid),
    .fifo_full_o(f_full), .fifo_empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae),
    .count_o(f_count), .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid, m_ovf, m_udf;
  int            passed = 0;
  int            total  = 0;

  function automatic logic [8:0] m_stat();
    int n = q.size();
    return {5'(n), n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2};
  endfunction

  function automatic logic [DW-1:0] m_head();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock of stimulus; the model applies the FIFO rules for that edge.
  task automatic step(input logic w, input logic r,
                      input logic [DW-1:0] d, input logic c);
    bit full, empty;
    wr_en = w; rd_en = r; wr_data = d; err_clr = c;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    @(posedge clk);
    m_valid = 1'b0;
    if (r && !empty) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end
    if (w && !full) q.push_back(d);
    m_ovf = (w && full) || (m_ovf && !c);
    m_udf = (r && empty) || (m_udf && !c);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    err_clr = 1'b0; wr_data = '0;
    model_reset();
    #12;
    total++;
    if ({r_stat, r_valid, r_data, r_ovf, r_udf} !== {9'b00000_0101, 1'b0, 32'h0, 2'b00})
      $display("FAIL reset_reg got stat=%b v=%b d=%h e=%b%b",
               r_stat, r_valid, r_data, r_ovf, r_udf);
    else passed++;
    total++;
    if ({f_stat, f_valid, f_data, f_ovf, f_udf} !== {9'b00000_0101, 1'b0, 32'h0, 2'b00})
      $display("FAIL reset_fwft got stat=%b v=%b d=%h e=%b%b",
               f_stat, f_valid, f_data, f_ovf, f_udf);
    else passed++;
    #1 areset = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, DW'(i), 1'b0);
      total++;
      if (r_count !== 5'(i + 1) || r_af !== (i + 1 >= 14) || r_full !== (i == DEPTH - 1))
        $display("FAIL fill_%0d got count=%0d af=%b full=%b want count=%0d",
                 i, r_count, r_af, r_full, i + 1);
      else passed++;
    end
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    total++;
    if ({r_ovf, r_full, r_count, f_data} !== {1'b1, 1'b1, 5'd16, 32'h0})
      $display("FAIL overflow got ovf=%b full=%b count=%0d head=%h want 1 1 16 0",
               r_ovf, r_full, r_count, f_data);
    else passed++;
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      total++;
      if (r_valid !== 1'b1 || r_data !== DW'(i) || r_ae !== (15 - i <= 2))
        $display("FAIL drain_%0d got v=%b d=%h ae=%b want 1 %h %b",
                 i, r_valid, r_data, r_ae, i, (15 - i <= 2));
      else passed++;
    end
    step(1'b0, 1'b0, '0, 1'b0);
    total++;
    if ({r_valid, r_data, r_empty, r_ae, r_count} !== {1'b0, 32'd15, 1'b1, 1'b1, 5'd0})
      $display("FAIL drained got v=%b d=%h empty=%b ae=%b count=%0d",
               r_valid, r_data, r_empty, r_ae, r_count);
    else passed++;
  endtask

  task automatic test_fwft();
    step(1'b1, 1'b0, 32'hA5, 1'b0);
    total++;
    if ({f_valid, f_data, r_valid} !== {1'b1, 32'hA5, 1'b0})
      $display("FAIL fwft_show got v=%b d=%h rv=%b want 1 a5 0",
               f_valid, f_data, r_valid);
    else passed++;
    step(1'b0, 1'b1, '0, 1'b0);
    total++;
    if ({f_empty, f_valid, r_valid, r_data} !== {1'b1, 1'b0, 1'b1, 32'hA5})
      $display("FAIL fwft_pop got empty=%b v=%b rv=%b rd=%h want 1 0 1 a5",
               f_empty, f_valid, r_valid, r_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(100 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      want = (k < 5) ? DW'(100 + k) : DW'(200 + k - 5);
      step(1'b1, 1'b1, DW'(200 + k), 1'b0);
      total++;
      if (r_count !== 5'd5 || r_valid !== 1'b1 || r_data !== want || f_count !== 5'd5)
        $display("FAIL b2b_%0d got count=%0d v=%b d=%h want 5 1 %h",
                 k, r_count, r_valid, r_data, want);
      else passed++;
    end
    total++;
    if (f_data !== DW'(235))
      $display("FAIL b2b_head got %h want %h", f_data, DW'(235));
    else passed++;
  endtask

  task automatic test_err_clr();
    int guard = 0;
    while (q.size() != 0 && guard < 40) begin
      step(1'b0, 1'b1, '0, 1'b0);
      guard++;
    end
    total++;
    if (r_empty !== 1'b1)
      $display("FAIL err_drain got empty=%b want 1", r_empty);
    else passed++;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b1);
    total++;
    if ({r_udf, f_udf} !== 2'b11)
      $display("FAIL udf_set_wins got %b%b want 11", r_udf, f_udf);
    else passed++;
    step(1'b0, 1'b0, '0, 1'b1);
    total++;
    if ({r_udf, f_udf} !== 2'b00)
      $display("FAIL udf_clear got %b%b want 00", r_udf, f_udf);
    else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(32'h700 + i), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b1, 1'b0, 32'h707, 1'b0);
    total++;
    if (r_count !== 5'd7 || r_data !== 32'h700)
      $display("FAIL pre_reset got count=%0d d=%h want 7 700", r_count, r_data);
    else passed++;
    #2 areset = 1'b1;
    #1;
    total++;
    if ({r_stat, r_valid, r_data, f_stat, f_valid, f_data} !==
        {9'b00000_0101, 1'b0, 32'h0, 9'b00000_0101, 1'b0, 32'h0})
      $display("FAIL async_reset got rs=%b rv=%b rd=%h fs=%b fv=%b fd=%h",
               r_stat, r_valid, r_data, f_stat, f_valid, f_data);
    else passed++;
    wr_en = 1'b1; wr_data = 32'h1234;
    @(posedge clk);
    #1;
    total++;
    if (r_count !== 5'd0 || f_valid !== 1'b0)
      $display("FAIL write_in_reset got count=%0d fv=%b want 0 0", r_count, f_valid);
    else passed++;
    wr_en = 1'b0;
    #3 areset = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 32'hBEEF, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    total++;
    if ({r_valid, r_data, r_empty} !== {1'b1, 32'hBEEF, 1'b1})
      $display("FAIL post_reset got v=%b d=%h empty=%b want 1 beef 1",
               r_valid, r_data, r_empty);
    else passed++;
  endtask

  task automatic test_random();
    int bias;
    logic w, r, c;
    for (int n = 0; n < 400; n++) begin
      case ((n / 50) % 3)
        0: bias = 80;
        1: bias = 20;
        default: bias = 50;
      endcase
      w = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < 100 - bias);
      c = ($urandom_range(0, 9) == 0);
      step(w, r, $urandom, c);
      total++;
      if ({r_stat, r_valid, r_data, r_ovf, r_udf} !== {m_stat(), m_valid, m_data, m_ovf, m_udf})
        $display("FAIL rand_reg_%0d got s=%b v=%b d=%h e=%b%b want s=%b v=%b d=%h e=%b%b",
                 n, r_stat, r_valid, r_data, r_ovf, r_udf,
                 m_stat(), m_valid, m_data, m_ovf, m_udf);
      else passed++;
      total++;
      if ({f_stat, f_valid, f_ovf, f_udf} !== {m_stat(), q.size() != 0, m_ovf, m_udf} ||
          (q.size() != 0 && f_data !== m_head()))
        $display("FAIL rand_fwft_%0d got s=%b v=%b d=%h want s=%b d=%h",
                 n, f_stat, f_valid, f_data, m_stat(), m_head());
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_fwft();
    test_back_to_back();
    test_err_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
